// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO with flush; push and pop may coincide when full
module fetch_queue import fetch_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fq_entry_t                wdata,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fq_entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_pop, do_push;
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
    assign head    = (count != '0) ? mem[rptr] : '0;
    // pointer and occupancy bookkeeping; flush empties the queue at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // entry storage needs no reset: head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/FSM fetch stage feeding decode through fetch_queue (optional FETCH_MISALIGN_EN)
module fetch_unit import fetch_pkg::*; #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] icache_addr,
    output logic        icache_rd_en,
    input  logic [31:0] icache_data,
    input  logic        icache_stall,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc,
    input  logic        dec_ready,
    output logic        dec_misalign
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    fetch_state_t  state;
    logic [63:0]   pc;
    logic [CW-1:0] count;
    fq_entry_t     head, push_entry;
    logic space, misaligned, mis_push, fetch_ok, push, pop;
    assign dec_valid    = count != '0;
    assign space        = (count < CW'(FQ_DEPTH)) | (dec_valid & dec_ready);
`ifdef FETCH_MISALIGN_EN
    logic mis_done;
    assign misaligned = pc[1:0] != 2'b00;
    assign mis_push   = (state == RUN) & !redir_valid & space & misaligned & !mis_done;
    // a misaligned PC yields exactly one nop marker until the next redirect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mis_done <= 1'b0;
        else mis_done <= redir_valid ? 1'b0 : (mis_done | mis_push);
    end
`else
    assign misaligned = 1'b0;
    assign mis_push   = 1'b0;
`endif
    assign icache_addr  = pc;
    assign icache_rd_en = (state == RUN) & !redir_valid & space & !misaligned;
    assign fetch_ok     = icache_rd_en & !icache_stall;
    assign push         = fetch_ok | mis_push;
    assign pop          = dec_valid & dec_ready;
    assign push_entry   = '{pc: pc, instr: mis_push ? NOP_INSTR : icache_data, misalign: mis_push};
    assign dec_instr    = head.instr;
    assign dec_pc       = head.pc;
    assign dec_misalign = head.misalign;
    // FSM and PC: redirect reloads PC and forces a one-cycle flush bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else if (redir_valid) begin
            state <= FLUSH;
            pc    <= redir_pc;
        end else begin
            state <= RUN;
            pc    <= fetch_ok ? pc + 64'(INSTR_BYTES) : pc;
        end
    end
    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redir_valid),
        .push    (push),
        .pop     (pop),
        .wdata   (push_entry),
        .head    (head),
        .count   (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, reset/redirect sequences and randomized scoreboard for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] icache_addr;
    logic        icache_rd_en;
    logic [31:0] icache_data;
    logic        icache_stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [63:0] redir_pc = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        dec_misalign;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        ready, stall, redir;
        logic [63:0] rpc;
        logic        valid, rd_en;
        logic [63:0] pc, addr;
    } vec_t;
    vec_t tbl [26];

    fetch_unit #(.RESET_PC(64'h1000), .FQ_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .icache_addr(icache_addr), .icache_rd_en(icache_rd_en),
        .icache_data(icache_data), .icache_stall(icache_stall), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .dec_misalign(dec_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction
    assign icache_data = mem_word(icache_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi, input bit release_rst);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            dec_ready    = tbl[i].ready;
            icache_stall = tbl[i].stall;
            redir_valid  = tbl[i].redir;
            redir_pc     = tbl[i].rpc;
            if (release_rst && i == lo) reset_n = 1'b1;
            #1;
            chk($sformatf("row%0d_valid", i), 64'(dec_valid), 64'(tbl[i].valid));
            chk($sformatf("row%0d_pc", i), dec_pc, tbl[i].pc);
            chk($sformatf("row%0d_instr", i), 64'(dec_instr), tbl[i].valid ? 64'(mem_word(tbl[i].pc)) : 64'h0);
            chk($sformatf("row%0d_rd_en", i), 64'(icache_rd_en), 64'(tbl[i].rd_en));
            chk($sformatf("row%0d_addr", i), icache_addr, tbl[i].addr);
            chk($sformatf("row%0d_misalign", i), 64'(dec_misalign), 64'h0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(dec_valid), 64'h0);
        chk({tag, "_rd_en"}, 64'(icache_rd_en), 64'h0);
        chk({tag, "_instr"}, 64'(dec_instr), 64'h0);
        chk({tag, "_pc"}, dec_pc, 64'h0);
        chk({tag, "_misalign"}, 64'(dec_misalign), 64'h0);
        chk({tag, "_addr"}, icache_addr, 64'h1000);
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic        was_redir;
        int          accepted;
        //          ready stall redir rpc                     valid rd_en pc                      addr
        tbl[0]  = '{1, 0, 0, 64'h0,                  0, 0, 64'h0,                  64'h1000};
        tbl[1]  = '{1, 0, 0, 64'h0,                  0, 1, 64'h0,                  64'h1000};
        tbl[2]  = '{1, 0, 0, 64'h0,                  1, 1, 64'h1000,               64'h1004};
        tbl[3]  = '{1, 0, 0, 64'h0,                  1, 1, 64'h1004,               64'h1008};
        tbl[4]  = '{0, 0, 0, 64'h0,                  1, 1, 64'h1008,               64'h100c};
        for (int i = 5; i <= 9; i++) tbl[i] = '{0, 0, 0, 64'h0, 1, 0, 64'h1008, 64'h1010};
        tbl[10] = '{1, 0, 0, 64'h0,                  1, 1, 64'h1008,               64'h1010};
        tbl[11] = '{1, 0, 0, 64'h0,                  1, 1, 64'h100c,               64'h1014};
        tbl[12] = '{1, 0, 0, 64'h0,                  1, 1, 64'h1010,               64'h1018};
        tbl[13] = '{1, 1, 0, 64'h0,                  1, 1, 64'h1014,               64'h101c};
        tbl[14] = '{1, 1, 0, 64'h0,                  1, 1, 64'h1018,               64'h101c};
        tbl[15] = '{1, 0, 0, 64'h0,                  0, 1, 64'h0,                  64'h101c};
        tbl[16] = '{0, 0, 0, 64'h0,                  1, 1, 64'h101c,               64'h1020};
        tbl[17] = '{1, 0, 1, 64'h2000,               1, 0, 64'h101c,               64'h1024};
        tbl[18] = '{1, 0, 0, 64'h0,                  0, 0, 64'h0,                  64'h2000};
        tbl[19] = '{1, 0, 0, 64'h0,                  0, 1, 64'h0,                  64'h2000};
        tbl[20] = '{1, 0, 0, 64'h0,                  1, 1, 64'h2000,               64'h2004};
        tbl[21] = '{1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h2004,               64'h2008};
        tbl[22] = '{1, 0, 0, 64'h0,                  0, 0, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC};
        tbl[23] = '{1, 0, 0, 64'h0,                  0, 1, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC};
        tbl[24] = '{1, 0, 0, 64'h0,                  1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        tbl[25] = '{1, 0, 0, 64'h0,                  1, 1, 64'h0,                  64'h4};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("reset");
        run_rows(0, 25, 1'b1);

        // asynchronous reset mid-stream clears outputs without waiting for a clock edge
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        run_rows(0, 3, 1'b1);

        // randomized traffic scored against the in-order PC stream rule
        exp_pc    = '0;
        was_redir = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            dec_ready    = $urandom_range(0, 3) != 0;
            icache_stall = $urandom_range(0, 4) == 0;
            redir_valid  = (i == 0) || ($urandom_range(0, 29) == 0);
            redir_pc     = {$urandom, $urandom} & ~64'h3;
            #1;
            if (was_redir) chk("rnd_flush_valid", 64'(dec_valid), 64'h0);
            if (redir_valid) chk("rnd_redir_rd_en", 64'(icache_rd_en), 64'h0);
            else if (dec_valid && dec_ready) begin
                chk("rnd_pc", dec_pc, exp_pc);
                chk("rnd_instr", 64'(dec_instr), 64'(mem_word(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                accepted++;
            end
            if (redir_valid) exp_pc = redir_pc;
            was_redir = redir_valid;
        end
        chk("rnd_progress", 64'(accepted >= 50), 64'h1);

`ifdef FETCH_MISALIGN_EN
        @(negedge clk);
        dec_ready = 1'b0; icache_stall = 1'b0; redir_valid = 1'b1; redir_pc = 64'h2002;
        @(negedge clk);
        redir_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mis_rd_en_blocked", 64'(icache_rd_en), 64'h0);
        @(negedge clk);
        #1;
        chk("mis_valid", 64'(dec_valid), 64'h1);
        chk("mis_flag", 64'(dec_misalign), 64'h1);
        chk("mis_instr", 64'(dec_instr), 64'h13);
        chk("mis_pc", dec_pc, 64'h2002);
        chk("mis_rd_en_held", 64'(icache_rd_en), 64'h0);
        @(negedge clk);
        dec_ready = 1'b1;
        #1;
        chk("mis_single_pc", dec_pc, 64'h2002);
        @(negedge clk);
        #1;
        chk("mis_single_valid", 64'(dec_valid), 64'h0);
        chk("mis_still_blocked", 64'(icache_rd_en), 64'h0);
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 64'h2004;
        @(negedge clk);
        redir_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mis_recover_pc", dec_pc, 64'h2004);
        chk("mis_recover_flag", 64'(dec_misalign), 64'h0);
        chk("mis_recover_instr", 64'(dec_instr), 64'(mem_word(64'h2004)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
